pwm_multi: RTL

- Multi-channel PWM generator; successor to the single-channel PWM block.
- All channels share one period counter. The period is programmable, and each channel has its own duty register.
- Duty and period writes go to shadow registers. Shadows load into active registers only at the period boundary, giving glitch-free updates.
- Sits behind a simple register write port, driven by an I2C slave register bridge or local control logic.

---
 rtl/pwm_multi.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared period counter and shadowed duty/period registers.
// Define PWM_CENTER_ALIGNED_EN for up/down (center-aligned) counting.
module pwm_multi #(
    parameter int CHANNELS  = 4,
    parameter int BITS      = 8,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [BITS-1:0]      wr_data,
    output logic [CHANNELS-1:0]  out,
    output logic                 cycle_start
);

    localparam logic [ADDR_BITS-1:0] PER_ADDR = ADDR_BITS'(CHANNELS);
    localparam logic [ADDR_BITS-1:0] CTL_ADDR = ADDR_BITS'(CHANNELS + 1);
    localparam logic [BITS-1:0]      ONE      = BITS'(1);

    logic [BITS-1:0]     cnt_q, cnt_d;
    logic                en_q, en_d;
    logic [BITS-1:0]     per_sh_q, per_sh_d;
    logic [BITS-1:0]     per_act_q, per_act_d;
    logic [BITS-1:0]     duty_sh_q [CHANNELS];
    logic [BITS-1:0]     duty_sh_d [CHANNELS];
    logic [BITS-1:0]     duty_act_q [CHANNELS];
    logic [BITS-1:0]     duty_act_d [CHANNELS];
    logic [CHANNELS-1:0] out_q, out_d;
    logic                cs_q, cs_d;
    logic                load;
`ifdef PWM_CENTER_ALIGNED_EN
    logic                dir_q, dir_d;
`endif

    always_comb begin
        cnt_d      = cnt_q;
        en_d       = en_q;
        per_sh_d   = per_sh_q;
        per_act_d  = per_act_q;
        duty_sh_d  = duty_sh_q;
        duty_act_d = duty_act_q;
        out_d      = '0;
        cs_d       = 1'b0;
        load       = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
        dir_d      = dir_q;
`endif
        if (!en_q) begin
            // Idle: keep actives tracking shadows so enabling starts fresh
            cnt_d = '0;
            load  = 1'b1;
`ifdef PWM_CENTER_ALIGNED_EN
            dir_d = 1'b0;
`endif
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                out_d[n] = (cnt_q < duty_act_q[n]);
            end
            cs_d = (cnt_q == '0);
`ifdef PWM_CENTER_ALIGNED_EN
            if (!dir_q) begin
                if (cnt_q == per_act_q) begin
                    if (cnt_q <= ONE) begin
                        cnt_d = '0;
                        load  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ONE;
                        dir_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else if (cnt_q <= ONE) begin
                cnt_d = '0;
                dir_d = 1'b0;
                load  = 1'b1;
            end else begin
                cnt_d = cnt_q - ONE;
            end
`else
            if (cnt_q == per_act_q) begin
                cnt_d = '0;
                load  = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
`endif
        end
        if (load) begin
            per_act_d  = per_sh_q;
            duty_act_d = duty_sh_q;
        end
        // Shadow writes land after the load, so they wait for the next boundary
        if (wr_en) begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (wr_addr == ADDR_BITS'(n)) duty_sh_d[n] = wr_data;
            end
            if (wr_addr == PER_ADDR) per_sh_d = wr_data;
            if (wr_addr == CTL_ADDR) en_d = wr_data[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            en_q      <= 1'b0;
            per_sh_q  <= '1;
            per_act_q <= '1;
            for (int n = 0; n < CHANNELS; n++) begin
                duty_sh_q[n]  <= '0;
                duty_act_q[n] <= '0;
            end
            out_q     <= '0;
            cs_q      <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            per_sh_q   <= per_sh_d;
            per_act_q  <= per_act_d;
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            out_q      <= out_d;
            cs_q       <= cs_d;
`ifdef PWM_CENTER_ALIGNED_EN
            dir_q      <= dir_d;
`endif
        end
    end

    assign out         = out_q;
    assign cycle_start = cs_q;

endmodule
